// File: rtl/pulse_train_gen_pkg.sv
// Shared types for the pulse-train generator: per-channel FSM state encoding.
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/pulse_train_gen_channel.sv
// One pulse-train channel: IDLE/HIGH/LOW FSM with a phase counter and a pulse counter.
module pulse_train_gen_channel
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter bit          RETRIGGER = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] high_len_i,
  input  logic [CNT_W-1:0] low_len_i,
  input  logic [CNT_W-1:0] pulses_i,
  output logic             signal_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  ch_state_e        state_q;
  logic [CNT_W-1:0] phase_q, pulse_q, high_q, low_q;
  logic             signal_q, busy_q, done_q;

  logic [CNT_W-1:0] high_clamp, low_clamp;
  logic             do_load;

  // Zero lengths are stretched to one cycle so every edge stays visible.
  assign high_clamp = (high_len_i == '0) ? One : high_len_i;
  assign low_clamp  = (low_len_i == '0) ? One : low_len_i;

  always_comb begin
    do_load = 1'b0;
    if (start_i && !stop_i) begin
      do_load = (state_q == StIdle) || RETRIGGER;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      pulse_q  <= '0;
      high_q   <= '0;
      low_q    <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (do_load) begin
        state_q  <= StHigh;
        high_q   <= high_clamp;
        low_q    <= low_clamp;
        pulse_q  <= pulses_i;
        phase_q  <= high_clamp;
        signal_q <= 1'b1;
        busy_q   <= 1'b1;
      end else begin
        case (state_q)
          StIdle: ;
          StHigh, StLow: begin
            if (stop_i) begin
              state_q  <= StIdle;
              signal_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else if (phase_q != One) begin
              phase_q <= phase_q - One;
            end else if (state_q == StLow) begin
              state_q  <= StHigh;
              phase_q  <= high_q;
              signal_q <= 1'b1;
            end else if (pulse_q == One) begin
              state_q  <= StIdle;
              signal_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              // A pulse count of zero means continuous, so it never decrements.
              state_q  <= StLow;
              phase_q  <= low_q;
              signal_q <= 1'b0;
              if (pulse_q != '0) pulse_q <= pulse_q - One;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign signal_o = signal_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse-train generator: replicates independent channels over packed config buses.
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_W     = 8,
  parameter bit          RETRIGGER = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS*CNT_W-1:0] high_len,
  input  logic [CHANNELS*CNT_W-1:0] low_len,
  input  logic [CHANNELS*CNT_W-1:0] pulses,
  output logic [CHANNELS-1:0]       signal,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_train_gen_channel #(
      .CNT_W    (CNT_W),
      .RETRIGGER(RETRIGGER)
    ) u_channel (
      .clk_i     (clock),
      .rst_ni    (reset_n),
      .start_i   (start[i]),
      .stop_i    (stop[i]),
      .high_len_i(high_len[i*CNT_W +: CNT_W]),
      .low_len_i (low_len[i*CNT_W +: CNT_W]),
      .pulses_i  (pulses[i*CNT_W +: CNT_W]),
      .signal_o  (signal[i]),
      .busy_o    (busy[i]),
      .done_o    (done[i])
    );
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: two instances (retrigger off/on) checked against an age-based model.
module tb_pulse_train_gen;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [NCH-1:0]   start, stop;
  logic [NCH*W-1:0] high_len, low_len, pulses;
  logic [NCH-1:0]   sig0, busy0, done0, sig1, busy1, done1;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: per instance/channel, active flag, cycles since last (re)start and latched config.
  int       m_act[2][NCH];
  int       m_age[2][NCH];
  int       m_h[2][NCH], m_l[2][NCH], m_p[2][NCH];
  logic [NCH-1:0] e_sig[2], e_busy[2], e_done[2];

  always #5 clock = ~clock;

  pulse_train_gen #(.CHANNELS(NCH), .CNT_W(W), .RETRIGGER(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .high_len(high_len),
    .low_len(low_len), .pulses(pulses), .signal(sig0), .busy(busy0), .done(done0)
  );

  pulse_train_gen #(.CHANNELS(NCH), .CNT_W(W), .RETRIGGER(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .high_len(high_len),
    .low_len(low_len), .pulses(pulses), .signal(sig1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic latch(input int d, input int c);
    int h, l;
    h = int'(high_len[c*W +: W]);
    l = int'(low_len[c*W +: W]);
    m_h[d][c]   = (h == 0) ? 1 : h;
    m_l[d][c]   = (l == 0) ? 1 : l;
    m_p[d][c]   = int'(pulses[c*W +: W]);
    m_age[d][c] = 0;
    m_act[d][c] = 1;
  endtask

  task automatic model_edge(input int d, input int c);
    int burst;
    e_done[d][c] = 1'b0;
    if (!reset_n) begin
      m_act[d][c] = 0;
    end else if (m_act[d][c] != 0 && stop[c]) begin
      m_act[d][c]  = 0;
      e_done[d][c] = 1'b1;
    end else if (m_act[d][c] != 0 && start[c] && d == 1) begin
      latch(d, c);
    end else if (m_act[d][c] != 0) begin
      m_age[d][c]++;
      burst = m_p[d][c] * m_h[d][c] + (m_p[d][c] - 1) * m_l[d][c];
      if (m_p[d][c] != 0 && m_age[d][c] == burst) begin
        m_act[d][c]  = 0;
        e_done[d][c] = 1'b1;
      end
    end else if (start[c] && !stop[c]) begin
      latch(d, c);
    end
    e_busy[d][c] = (m_act[d][c] != 0);
    e_sig[d][c]  = (m_act[d][c] != 0) &&
                   ((m_age[d][c] % (m_h[d][c] + m_l[d][c])) < m_h[d][c]);
  endtask

  // One clock: advance the model on the edge, then compare both instances 1 time unit later.
  task automatic step();
    @(posedge clock);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) model_edge(d, c);
    #1;
    chk("signal_r0", 32'(sig0), 32'(e_sig[0]));
    chk("busy_r0", 32'(busy0), 32'(e_busy[0]));
    chk("done_r0", 32'(done0), 32'(e_done[0]));
    chk("signal_r1", 32'(sig1), 32'(e_sig[1]));
    chk("busy_r1", 32'(busy1), 32'(e_busy[1]));
    chk("done_r1", 32'(done1), 32'(e_done[1]));
  endtask

  task automatic set_cfg(input int c, input int h, input int l, input int p);
    high_len[c*W +: W] = W'(h);
    low_len[c*W +: W]  = W'(l);
    pulses[c*W +: W]   = W'(p);
  endtask

  task automatic quiesce();
    start = '0;
    stop  = '1;
    step();
    stop = '0;
    step();
  endtask

  initial begin
    logic [19:0] pat;
    logic [7:0]  tog;
    int          busy_cnt, hi0, hi1, dn1;

    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        m_act[d][c] = 0; m_age[d][c] = 0;
        m_h[d][c] = 1; m_l[d][c] = 1; m_p[d][c] = 1;
      end
    reset_n = 1'b0;
    start   = '1;
    stop    = '0;
    for (int c = 0; c < NCH; c++) set_cfg(c, 2, 2, 1);

    // Reset held with start asserted keeps everything quiet.
    repeat (3) begin
      step();
      chk("reset_sig", 32'(sig0 | sig1 | busy0 | busy1 | done0 | done1), 32'd0);
    end
    reset_n = 1'b1;
    step();
    chk("post_reset_start", 32'(sig0), 32'hF);
    quiesce();

    // Single burst on ch0: H=4 L=4 P=3.
    set_cfg(0, 4, 4, 3);
    pat = '0;
    busy_cnt = 0;
    start[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      start[0] = 1'b0;
      pat = {pat[18:0], sig0[0]};
      busy_cnt += int'(busy0[0]);
    end
    chk("burst_pattern", 32'(pat), 32'b1111_0000_1111_0000_1111);
    chk("burst_busy_cycles", 32'(busy_cnt), 32'd20);
    step();
    chk("burst_done", 32'(done0[0]), 32'd1);
    chk("burst_end_sig", 32'(sig0[0]), 32'd0);
    step();
    chk("burst_done_once", 32'(done0[0]), 32'd0);

    // Clamp + continuous on ch1, then stop.
    set_cfg(1, 0, 0, 0);
    start[1] = 1'b1;
    tog = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      start[1] = 1'b0;
      tog = {tog[6:0], sig1[1]};
    end
    chk("continuous_toggle", 32'(tog), 32'b1010_1010);
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
    chk("stop_sig", 32'(sig1[1]), 32'd0);
    chk("stop_done", 32'(done1[1]), 32'd1);

    // Retrigger on ch3: H=5 P=1, second start two edges after the first.
    set_cfg(3, 5, 3, 1);
    hi0 = 0; hi1 = 0; dn1 = 0;
    for (int i = 0; i < 12; i++) begin
      start[3] = (i == 0 || i == 2);
      step();
      hi0 += int'(sig0[3]);
      hi1 += int'(sig1[3]);
      dn1 += int'(done1[3]);
    end
    start[3] = 1'b0;
    chk("retrig0_high", 32'(hi0), 32'd5);
    chk("retrig1_high", 32'(hi1), 32'd7);
    chk("retrig1_done_count", 32'(dn1), 32'd1);

    // Start and stop together in IDLE do nothing.
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    step();
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    chk("start_stop_idle", 32'(busy0[0] | busy1[0]), 32'd0);

    // Reset in the middle of ch2's LOW phase.
    set_cfg(2, 2, 6, 2);
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_low_reset", 32'(sig0 | busy0 | done0 | sig1 | busy1 | done1), 32'd0);
    step();

    // All channels together with random configs, mid-burst config churn and sparse start/stop.
    for (int c = 0; c < NCH; c++)
      set_cfg(c, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
    start = '1;
    step();
    start = '0;
    for (int i = 0; i < 150; i++) begin
      for (int c = 0; c < NCH; c++) begin
        set_cfg(c, $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4));
        start[c] = ($urandom_range(0, 9) == 0);
        stop[c]  = ($urandom_range(0, 24) == 0);
      end
      step();
    end
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
